snare_sample_fetch: RTL and testbench



---
 rtl/snare_sample_fetch.sv | 176 +++++++++++++++++
 tb/tb_snare_sample_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/snare_sample_fetch.sv
// snare_sample_fetch
//
// Purpose:
//   Fetches one snare sample per tick. On each tick it latches the address
//   from the sample-address counter and reads the sample ROM, which has a
//   1-cycle read latency. It then arithmetically shifts the ROM word by the
//   volume setting and offers the result to the codec writer over a
//   valid/ready handshake. Once the counter has parked at ENDADDR, the
//   delivered sample is exactly zero (silence).
//
// Ports:
//   clk           system clock, all logic on posedge
//   resetn        synchronous, active-low reset
//   en            sample tick, one clk wide (same strobe that advances counter)
//   count         current sample address from the counter (pre-increment)
//   vol           attenuation, sample_out = rom_q >>> vol
//   rom_addr      ROM address (registered)
//   rom_q         ROM data, valid 1 clk after rom_addr
//   sample_out    signed sample to the codec writer
//   sample_valid  sample_out holds a new sample
//   sample_ready  codec writer accepts this cycle
//   overrun       sticky: a tick arrived while the block was busy
//   clr_ovf       clears overrun
//   ovr_count     (only with SNARE_FETCH_OVR_CNT_EN) saturating count of
//                 dropped ticks
//   state_dbg     current FSM state (IDLE=0, ADDR=1, WAIT=2, HOLD=3)
//
// Handshake: sample_valid rises with a new sample_out. Both are held stable
// until the first posedge on which sample_valid & sample_ready are both high.
// That edge is the transfer. sample_valid then drops, while sample_out keeps
// its last value. sample_ready is ignored whenever sample_valid is low.
//
// Optional feature macro: SNARE_FETCH_OVR_CNT_EN adds the ovr_count output.

module snare_sample_fetch #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 16,
  parameter int ENDADDR = 16481
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [ADDR_W-1:0] count,
  input  logic [2:0]        vol,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  input  logic              clr_ovf,
`ifdef SNARE_FETCH_OVR_CNT_EN
  output logic [7:0]        ovr_count,
`endif
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [ADDR_W-1:0] END_A = ADDR_W'(ENDADDR);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              eos_q, eos_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic signed [DATA_W-1:0] rom_s;
  logic signed [DATA_W-1:0] shifted;
  logic                     drop;

  // Sign-preserving attenuation: negative samples stay negative.
  assign rom_s   = $signed(rom_q);
  assign shifted = rom_s >>> vol;

  // A tick outside IDLE is dropped. The transaction in flight is untouched.
  assign drop = en && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    rom_addr_d = rom_addr_q;
    eos_d      = eos_q;
    sample_d   = sample_q;
    valid_d    = valid_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          rom_addr_d = count;
          eos_d      = (count == END_A);
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        // ROM is registering rom_addr during this cycle.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        sample_d = eos_q ? '0 : shifted;
        valid_d  = 1'b1;
        state_d  = S_HOLD;
      end
      S_HOLD: begin
        if (sample_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Set dominates clear when both happen on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      eos_q      <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      eos_q      <= eos_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef SNARE_FETCH_OVR_CNT_EN
  logic [7:0] cnt_q, cnt_d, cnt_base;

  // Clear first, then increment. A same-edge clear and drop therefore yields 1.
  always_comb begin
    cnt_base = clr_ovf ? 8'd0 : cnt_q;
    cnt_d    = cnt_base;
    if (drop && (cnt_base != 8'hFF)) begin
      cnt_d = cnt_base + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovr_count = cnt_q;
`endif

  assign rom_addr     = rom_addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = ovf_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_snare_sample_fetch.sv
module tb_snare_sample_fetch;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        en;
  logic [14:0] count;
  logic [2:0]  vol;
  logic [14:0] rom_addr;
  logic [15:0] rom_q = 16'h0000;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        clr_ovf;
  logic [1:0]  state_dbg;
`ifdef SNARE_FETCH_OVR_CNT_EN
  logic [7:0]  ovr_count;
`endif

  snare_sample_fetch dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .count        (count),
    .vol          (vol),
    .rom_addr     (rom_addr),
    .rom_q        (rom_q),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_ovf      (clr_ovf),
`ifdef SNARE_FETCH_OVR_CNT_EN
    .ovr_count    (ovr_count),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ROM model (1-cycle read latency) ----------------
  logic [15:0] rom_mem [0:32767];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  int n_expect = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pops on every handshake and compares the delivered sample.
  always @(negedge clk) begin
    #1;
    if (resetn && sample_valid && sample_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        check("unexpected_sample", 32'(sample_out), 32'hDEAD);
      end else begin
        check("sample_out", 32'(sample_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [14:0] addr;
    logic [15:0] rom;
    logic [2:0]  vol;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks (called right after a negedge) ----------------
  task automatic start_txn(input logic [14:0] a, input logic [15:0] d,
                           input logic [2:0] v, input logic [15:0] e);
    rom_mem[a] = d;
    vol   = v;
    count = a;
    en    = 1'b1;
    exp_q.push_back(e);
    n_expect++;
    @(negedge clk);
    en    = 1'b0;
    count = 15'($urandom_range(0, 32767));
  endtask

  task automatic run_vec(input vec_t t);
    start_txn(t.addr, t.rom, t.vol, t.exp);
    check("rom_addr_n1", 32'(rom_addr), 32'(t.addr));
    check("state_addr", 32'(state_dbg), 32'(S_ADDR));
    check("valid_n1", 32'(sample_valid), 32'd0);
    @(negedge clk);
    check("valid_n2", 32'(sample_valid), 32'd0);
    check("state_wait", 32'(state_dbg), 32'(S_WAIT));
    @(negedge clk);
    check("valid_n3", 32'(sample_valid), 32'd1);
    check("state_hold", 32'(state_dbg), 32'(S_HOLD));
    @(negedge clk);
    check("valid_drop", 32'(sample_valid), 32'd0);
    check("state_idle", 32'(state_dbg), 32'(S_IDLE));
    check("sample_kept", 32'(sample_out), 32'(t.exp));
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom_mem[i] = 16'(i * 7) ^ 16'h5A5A;

    vecs[0] = '{15'd100,   16'h1234, 3'd0, 16'h1234};
    vecs[1] = '{15'd200,   16'h8000, 3'd2, 16'hE000};
    vecs[2] = '{15'd300,   16'hFFFF, 3'd7, 16'hFFFF};
    vecs[3] = '{15'd16481, 16'h7FFF, 3'd0, 16'h0000};
    vecs[4] = '{15'd400,   16'h7FFF, 3'd3, 16'h0FFF};
    vecs[5] = '{15'd500,   16'h8001, 3'd1, 16'hC000};
    vecs[6] = '{15'd16482, 16'h0042, 3'd1, 16'h0021};
    vecs[7] = '{15'd16480, 16'h9ABC, 3'd4, 16'hF9AB};

    resetn = 1'b0; en = 1'b0; count = '0; vol = '0;
    sample_ready = 1'b1; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state_dbg), 32'(S_IDLE));
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Table-driven: back-to-back transactions at minimum turnaround.
    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    check("no_overrun_yet", 32'(overrun), 32'd0);

    // Backpressure for 10 clks, with a tick dropped in the middle.
    sample_ready = 1'b0;
    start_txn(15'd600, 16'h4321, 3'd0, 16'h4321);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      en = 1'b0;
      check("bp_valid", 32'(sample_valid), 32'd1);
      check("bp_sample", 32'(sample_out), 32'h4321);
      if (i == 5) begin
        en    = 1'b1;
        count = 15'd700;
      end
      @(negedge clk);
    end
    en = 1'b0;
    check("ovf_set", 32'(overrun), 32'd1);
    check("bp_state_hold", 32'(state_dbg), 32'(S_HOLD));
`ifdef SNARE_FETCH_OVR_CNT_EN
    check("ovr_count_1", 32'(ovr_count), 32'd1);
`endif
    sample_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", 32'(sample_valid), 32'd0);
    check("bp_released_idle", 32'(state_dbg), 32'(S_IDLE));
    run_vec('{15'd800, 16'hF000, 3'd2, 16'hFC00});
    check("ovf_sticky", 32'(overrun), 32'd1);

    // Clear, then a clear coinciding with a drop.
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", 32'(overrun), 32'd0);
`ifdef SNARE_FETCH_OVR_CNT_EN
    check("ovr_count_clr", 32'(ovr_count), 32'd0);
`endif
    start_txn(15'd900, 16'h0100, 3'd4, 16'h0010);
    en = 1'b1; clr_ovf = 1'b1; count = 15'd901;
    @(negedge clk);
    en = 1'b0; clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overrun), 32'd1);
`ifdef SNARE_FETCH_OVR_CNT_EN
    check("ovr_count_set_wins", 32'(ovr_count), 32'd1);
`endif
    @(negedge clk);
    check("sw_valid", 32'(sample_valid), 32'd1);
    @(negedge clk);
    check("sw_idle", 32'(state_dbg), 32'(S_IDLE));

`ifdef SNARE_FETCH_OVR_CNT_EN
    // Saturation: 300 dropped ticks while held in HOLD.
    sample_ready = 1'b0;
    start_txn(15'd1000, 16'h0003, 3'd0, 16'h0003);
    @(negedge clk);
    @(negedge clk);
    en = 1'b1;
    repeat (300) @(negedge clk);
    en = 1'b0;
    check("ovr_count_sat", 32'(ovr_count), 32'd255);
    sample_ready = 1'b1;
    @(negedge clk);
`endif

    // Reset while in WAIT abandons the pending sample.
    start_txn(15'd1100, 16'h1111, 3'd0, 16'h1111);
    @(negedge clk);
    check("pre_rst_wait", 32'(state_dbg), 32'(S_WAIT));
    resetn = 1'b0;
    void'(exp_q.pop_back());
    n_expect--;
    @(negedge clk);
    resetn = 1'b1;
    check("wrst_valid", 32'(sample_valid), 32'd0);
    check("wrst_state", 32'(state_dbg), 32'(S_IDLE));
    check("wrst_sample", 32'(sample_out), 32'd0);
    check("wrst_overrun", 32'(overrun), 32'd0);
    check("wrst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("wrst_still_idle", 32'(sample_valid), 32'd0);
    end
    run_vec('{15'd1100, 16'h2468, 3'd1, 16'h1234});

    @(negedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("deliveries", 32'(n_deliv), 32'(n_expect));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
